// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and helpers for the I2C transaction arbiter
// Defines the I2C_SLICE(vec, k, w) macro for per-requester field slices.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_RUN       = 3'd2,
    ST_RSTART    = 3'd3,
    ST_WAIT_STOP = 3'd4,
    ST_DONE      = 3'd5
  } arb_state_t;

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

`ifndef I2C_SLICE
`define I2C_SLICE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - combinational round-robin picker
// Scans requests starting at ptr and wrapping; the smallest offset from ptr wins.
module i2c_rr_pick
  import i2c_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] k;

  // Walk offsets from farthest to nearest so the nearest set request overwrites.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      k = IDX_W'(wrap_idx(int'(ptr), off, NREQ));
      if (req[k]) begin
        onehot    = '0;
        onehot[k] = 1'b1;
        idx       = k;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin sequencer sharing one I2C master among NREQ requesters
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LEN_W   = 4,
  parameter int RS_HOLD = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic                    i2c_core_clk_i,
  input  logic                    reset_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*7-1:0]       addr_i,
  input  logic [NREQ-1:0]         rw_i,
  input  logic [NREQ*LEN_W-1:0]   len_i,
  input  logic [NREQ-1:0]         chain_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         done_o,
  output logic                    nack_o,
  output logic                    mst_enable_o,
  output logic                    mst_rw_o,
  output logic                    mst_repeat_start_o,
  output logic [I2C_ADDR_W-1:0]   mst_addr_o,
  input  logic                    mst_idle_i,
  input  logic                    mst_byte_done_i,
  input  logic                    mst_ack_err_i
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RS_W  = $clog2(RS_HOLD + 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [LEN_W-1:0] remain;
  logic             chain_q;
  logic             nack_flag;
  logic [RS_W-1:0]  rs_cnt;
  logic             wd_fire;

  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  logic [I2C_ADDR_W-1:0] addr_arr [NREQ];
  logic [LEN_W-1:0]      len_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign addr_arr[g] = `I2C_SLICE(addr_i, g, I2C_ADDR_W);
    assign len_arr[g]  = `I2C_SLICE(len_i, g, LEN_W);
  end

  i2c_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (req_i),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TMO_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  arb_state_t      wd_state;

  // Comparing against last cycle's state restarts the count on every transition.
  always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
    if (reset_i) begin
      wd_cnt   <= '0;
      wd_state <= ST_IDLE;
    end else begin
      wd_state <= state;
      if ((state != ST_LAUNCH && state != ST_RUN) || state != wd_state || mst_byte_done_i)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_fire = (wd_cnt == WD_W'(TMO_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign wd_fire    = 1'b0;
`endif

  always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state              <= ST_IDLE;
      ptr                <= '0;
      win                <= '0;
      remain             <= '0;
      chain_q            <= 1'b0;
      nack_flag          <= 1'b0;
      rs_cnt             <= '0;
      gnt_o              <= '0;
      done_o             <= '0;
      nack_o             <= 1'b0;
      mst_enable_o       <= 1'b0;
      mst_rw_o           <= 1'b0;
      mst_repeat_start_o <= 1'b0;
      mst_addr_o         <= '0;
    end else begin
      done_o <= '0;
      nack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mst_idle_i && pick_valid) begin
            win       <= pick_idx;
            gnt_o     <= pick_oh;
            chain_q   <= chain_i[pick_idx];
            remain    <= len_arr[pick_idx];
            nack_flag <= 1'b0;
            if (len_arr[pick_idx] == '0) begin
              done_o <= pick_oh;
              nack_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              mst_addr_o   <= addr_arr[pick_idx];
              mst_rw_o     <= rw_i[pick_idx];
              mst_enable_o <= 1'b1;
              state        <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          if (mst_ack_err_i || wd_fire) begin
            mst_enable_o <= 1'b0;
            nack_flag    <= 1'b1;
            state        <= ST_WAIT_STOP;
          end else if (!mst_idle_i) begin
            mst_enable_o <= 1'b0;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mst_ack_err_i || wd_fire) begin
            nack_flag <= 1'b1;
            state     <= ST_WAIT_STOP;
          end else if (mst_byte_done_i) begin
            remain <= remain - LEN_W'(1);
            if (remain == LEN_W'(1)) begin
              if (chain_q && req_i[win]) begin
                rs_cnt             <= '0;
                mst_repeat_start_o <= 1'b1;
                done_o             <= gnt_o;
                state              <= ST_RSTART;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
        end
        ST_RSTART: begin
          // Fields are relatched on the last hold cycle, after the requester updated them.
          if (rs_cnt == RS_W'(RS_HOLD - 1)) begin
            mst_repeat_start_o <= 1'b0;
            chain_q            <= chain_i[win];
            remain             <= len_arr[win];
            mst_addr_o         <= addr_arr[win];
            mst_rw_o           <= rw_i[win];
            if (len_arr[win] == '0) begin
              nack_flag <= 1'b1;
              state     <= ST_WAIT_STOP;
            end else begin
              state <= ST_RUN;
            end
          end else begin
            rs_cnt <= rs_cnt + RS_W'(1);
          end
        end
        ST_WAIT_STOP: begin
          if (mst_idle_i) begin
            done_o <= gnt_o;
            nack_o <= nack_flag;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt_o <= '0;
          ptr   <= (win == IDX_W'(NREQ - 1)) ? '0 : win + IDX_W'(1);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
